// File: rtl/ahb_apb_pkg.sv
// Shared types and default address map for the AHB-to-APB bridge controller.
//   htrans_e       : AHB transfer type encoding
//   hresp_e        : AHB response encoding
//   bridge_state_e : bridge sequencing states
//   DEF_SLV*_BASE, DEF_SLV_SIZE : default APB slave regions
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [31:0] DEF_SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] DEF_SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] DEF_SLV_SIZE  = 32'h0400_0000;

endpackage

// File: rtl/ahb_apb_addr_decode.sv
// Combinational APB slave address decoder.
//   i_addr : AHB address
//   o_sel  : one-hot slave select (bit n = slave n), 000 on a miss
//   o_hit  : address falls inside one of the three regions
module ahb_apb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
  parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
  parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
  parameter logic [31:0] SLV_SIZE  = DEF_SLV_SIZE
) (
  input  logic [31:0] i_addr,
  output logic [2:0]  o_sel,
  output logic        o_hit
);

  logic [31:0] w_off0, w_off1, w_off2;
  logic [2:0]  w_in;

  // Offset-from-base compare: base <= addr < base+size without the
  // base+size sum wrapping for a region that ends at the top of memory.
  assign w_off0 = i_addr - SLV0_BASE;
  assign w_off1 = i_addr - SLV1_BASE;
  assign w_off2 = i_addr - SLV2_BASE;
  assign w_in   = {(w_off2 < SLV_SIZE), (w_off1 < SLV_SIZE), (w_off0 < SLV_SIZE)};

  // Overlapping regions resolve to the lowest slave index.
  always_comb begin
    o_sel = 3'b000;
    if (w_in[0])      o_sel = 3'b001;
    else if (w_in[1]) o_sel = 3'b010;
    else if (w_in[2]) o_sel = 3'b100;
  end

  assign o_hit = |w_in;

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// Sequences single AHB transfers onto APB.
//   clk, resetn                  : clock, synchronous active-low reset
//   Hwrite/Hreadyin/Htrans/Hwdata/Haddr : AHB slave inputs
//   Hrdata/Hresp/Hreadyout       : AHB slave response (registered)
//   Penable/Pwrite/Pselx/Pwdata/Paddr   : APB master outputs (registered)
//   Prdata                       : APB read data
//   o_dbg_state                  : current sequencing state
//
// Handshake: an AHB address phase is taken when Hreadyin=1, Htrans is
// NONSEQ/SEQ and the bridge is in IDLE. The data phase then runs until the
// bridge drives Hreadyout=1; every cycle with Hreadyout=0 is a wait state.
module ahb_apb_bridge_ctrl
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [31:0] SLV0_BASE     = DEF_SLV0_BASE,
  parameter logic [31:0] SLV1_BASE     = DEF_SLV1_BASE,
  parameter logic [31:0] SLV2_BASE     = DEF_SLV2_BASE,
  parameter logic [31:0] SLV_SIZE      = DEF_SLV_SIZE
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          Hwrite,
  input  logic          Hreadyin,
  input  logic [1:0]    Htrans,
  input  logic [31:0]   Hwdata,
  input  logic [31:0]   Haddr,
  output logic [31:0]   Hrdata,
  output logic [1:0]    Hresp,
  output logic          Hreadyout,
  output logic          Penable,
  output logic          Pwrite,
  output logic [2:0]    Pselx,
  output logic [31:0]   Pwdata,
  output logic [31:0]   Paddr,
  input  logic [31:0]   Prdata,
  output bridge_state_e o_dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  bridge_state_e r_state, w_state_nxt;
  logic [3:0]    r_cnt;
  logic [2:0]    r_sel;
  logic [31:0]   r_hrdata, r_pwdata, r_paddr;
  logic [1:0]    r_hresp;
  logic          r_hreadyout, r_penable, r_pwrite;
  logic [2:0]    r_pselx;

  logic [2:0]    w_sel;
  logic          w_hit;
  logic          w_valid;
  logic          w_nxt_hreadyout, w_nxt_penable;
  hresp_e        w_nxt_hresp;
  logic [2:0]    w_nxt_pselx;

  ahb_apb_addr_decode #(
    .SLV0_BASE (SLV0_BASE),
    .SLV1_BASE (SLV1_BASE),
    .SLV2_BASE (SLV2_BASE),
    .SLV_SIZE  (SLV_SIZE)
  ) u_decode (
    .i_addr (Haddr),
    .o_sel  (w_sel),
    .o_hit  (w_hit)
  );

  assign w_valid = Hreadyin && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ)
                   && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid) w_state_nxt = !w_hit ? ST_ERR1 : (Hwrite ? ST_WLATCH : ST_SETUP);
      ST_WLATCH: w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
      ST_ERR1:   w_state_nxt = ST_ERR2;
      ST_ERR2:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being
  // entered: what a state "drives" is visible for the whole of that state.
  always_comb begin
    w_nxt_hreadyout = 1'b1;
    w_nxt_hresp     = HRESP_OKAY;
    w_nxt_penable   = 1'b0;
    w_nxt_pselx     = 3'b000;
    case (w_state_nxt)
      ST_WLATCH: w_nxt_hreadyout = 1'b0;
      ST_SETUP: begin
        w_nxt_hreadyout = 1'b0;
        // A read enters SETUP straight from IDLE, before r_sel is loaded.
        w_nxt_pselx     = (r_state == ST_IDLE) ? w_sel : r_sel;
      end
      ST_ACCESS: begin
        w_nxt_hreadyout = 1'b0;
        w_nxt_penable   = 1'b1;
        w_nxt_pselx     = r_sel;
      end
      ST_ERR1: begin
        w_nxt_hreadyout = 1'b0;
        w_nxt_hresp     = HRESP_ERROR;
      end
      ST_ERR2: w_nxt_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_sel       <= 3'b000;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= 32'd0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pselx     <= 3'b000;
      r_pwdata    <= 32'd0;
      r_paddr     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_hreadyout <= w_nxt_hreadyout;
      r_hresp     <= w_nxt_hresp;
      r_penable   <= w_nxt_penable;
      r_pselx     <= w_nxt_pselx;
      if (w_valid && w_hit) begin
        r_paddr  <= Haddr;
        r_pwrite <= Hwrite;
        r_sel    <= w_sel;
      end
      if (r_state == ST_WLATCH) r_pwdata <= Hwdata;
      if (r_state == ST_SETUP) r_cnt <= CNT_LOAD;
      else if (r_state == ST_ACCESS && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == ST_ACCESS && r_cnt == 4'd0 && !r_pwrite) r_hrdata <= Prdata;
    end
  end

  assign Hrdata      = r_hrdata;
  assign Hresp       = r_hresp;
  assign Hreadyout   = r_hreadyout;
  assign Penable     = r_penable;
  assign Pwrite      = r_pwrite;
  assign Pselx       = r_pselx;
  assign Pwdata      = r_pwdata;
  assign Paddr       = r_paddr;
  assign o_dbg_state = r_state;

endmodule
